load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_align.sv | 46 ++++
 rtl/load_store_unit.sv | 118 +++++++++++
 tb/tb_load_store_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states,
// default memory depth and the access legality check.
package lsu_pkg;

  localparam int LSU_MEM_WORDS = 1024;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_STORE  = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_t;

  // Unsigned widths exist only for loads; a store with them is illegal.
  function automatic logic lsu_access_err(input logic we, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic err;
    case (f3)
      F3_B:         err = 1'b0;
      F3_H:         err = off[0];
      F3_W:         err = (off != 2'b00);
      F3_BU, F3_HU: err = we;
      default:      err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction with sign/zero extension and
// byte/halfword merge of store data into a previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] load_word,
  input  logic [31:0] base_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    shifted = load_word >> {byte_off, 3'b000};
    lane_b  = shifted[7:0];
    lane_h  = byte_off[1] ? load_word[31:16] : load_word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_W:    load_data = load_word;
      F3_BU:   load_data = {24'h0, lane_b};
      F3_HU:   load_data = {16'h0, lane_h};
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    store_word = base_word;
    case (funct3)
      F3_B: store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (byte_off[1]) store_word[31:16] = wdata[15:0];
        else             store_word[15:0]  = wdata[15:0];
      end
      F3_W:    store_word = wdata;
      default: store_word = base_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a single-port word memory with combinational
// read. Define LSU_BOUNDS_CHECK_EN to reject word indices >= MEM_WORDS.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = LSU_MEM_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output lsu_state_t  dbg_state
);

`ifdef LSU_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  // Handshake: an access transfers on a rising edge where req_valid and
  // req_ready are both 1; req_ready is high only in IDLE, so the unit holds
  // one access at a time and ignores req_* until it is back in IDLE.
  lsu_state_t  state_q, state_d;
  logic        we_q, err_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, word_q;
  logic        accept, acc_err, oob;
  logic [31:0] load_data, store_word, word_idx;

  assign accept   = (state_q == ST_IDLE) && req_valid;
  assign oob      = BOUNDS_EN && ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
  assign acc_err  = lsu_access_err(req_we, req_funct3, req_addr[1:0]) || oob;
  assign word_idx = {2'b00, addr_q[31:2]};

  lsu_align u_align (
    .funct3     (f3_q),
    .byte_off   (addr_q[1:0]),
    .load_word  (mem_rdata),
    .base_word  (word_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        err_q   <= acc_err;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        word_q  <= 32'h0;
      end
      if (state_q == ST_LOAD)   word_q <= load_data;
      if (state_q == ST_RMW_RD) word_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (acc_err)                 state_d = ST_RESP;
          else if (!req_we)            state_d = ST_LOAD;
          else if (req_funct3 == F3_W) state_d = ST_STORE;
          else                         state_d = ST_RMW_RD;
        end
      end
      ST_LOAD:   state_d = ST_RESP;
      ST_RMW_RD: state_d = ST_STORE;
      ST_STORE:  state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    resp_err   = (state_q == ST_RESP) && err_q;
    resp_rdata = ((state_q == ST_RESP) && !we_q && !err_q) ? word_q : 32'h0;
    mem_we     = (state_q == ST_STORE);
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    if (state_q == ST_LOAD || state_q == ST_RMW_RD || state_q == ST_STORE)
      mem_addr = word_idx;
    if (state_q == ST_STORE)
      mem_wdata = store_word;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word memory model, driver task pushing
// expected responses, negedge monitor popping and comparing them.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  lsu_state_t  dbg_state;

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on rising edge, preloaded once.
  logic [31:0] mem [0:1023];
  logic        mem_loaded = 1'b0;
  assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'h0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h0000000B;
      mem[8] <= 32'h0A050102;
      mem_loaded <= 1'b1;
    end else if (mem_we && mem_addr < 32'd1024) begin
      mem[mem_addr[9:0]] <= mem_wdata;
    end
  end

  int checks = 0;
  int errors = 0;
  int neg_cnt = 0;
  int we_cnt = 0;
  int resp_cnt = 0;
  logic [31:0] last_load_addr = 32'h0;
  logic [64:0] exp_q[$];  // {err, rdata, negedge index of response}

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    logic [64:0] e;
    neg_cnt++;
    if (rst_n) begin
      if (mem_we) we_cnt++;
      if (dbg_state == ST_LOAD) last_load_addr = mem_addr;
      if (resp_valid) begin
        resp_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual=resp_valid required=none");
        end else begin
          e = exp_q.pop_front();
          check32("resp_rdata", resp_rdata, e[63:32]);
          check32("resp_err", {31'b0, resp_err}, {31'b0, e[64]});
          check32("resp_cycle", 32'(neg_cnt), e[31:0]);
        end
      end
    end
  end

  // Driver: present one access, scramble req_* while busy, wait for IDLE.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input int lat, input int exp_we);
    int we0;
    int n;
    we0 = we_cnt;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    exp_q.push_back({exp_err, exp_rd, 32'(neg_cnt + lat)});
    @(negedge clk); #1;
    req_we     = ~we;
    req_funct3 = 3'b010;
    req_addr   = 32'hFFFF_FFF0;
    req_wdata  = 32'h5A5A_5A5A;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=busy required=idle");
    end
    check32("mem_we_pulses", 32'(we_cnt - we0), 32'(exp_we));
    check32("idle_mem_addr", mem_addr, 32'h0);
    check32("idle_mem_wdata", mem_wdata, 32'h0);
    check32("resp_missing", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  initial begin
    int we0;
    int rc0;
    #1;
    check32("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check32("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    check32("rst_req_ready", {31'b0, req_ready}, 32'h1);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;

    issue(1'b0, F3_W,  32'h20, 32'h0, 32'h0A050102, 1'b0, 2, 0);
    issue(1'b0, F3_B,  32'h23, 32'h0, 32'h0000000A, 1'b0, 2, 0);
    issue(1'b0, F3_BU, 32'h21, 32'h0, 32'h00000001, 1'b0, 2, 0);
    issue(1'b0, F3_H,  32'h22, 32'h0, 32'h00000A05, 1'b0, 2, 0);
    issue(1'b1, F3_B,  32'h04, 32'h123456FF, 32'h0, 1'b0, 3, 1);
    check32("sb_word1", mem[1], 32'h000000FF);
    issue(1'b0, F3_B,  32'h04, 32'h0, 32'hFFFFFFFF, 1'b0, 2, 0);
    issue(1'b0, F3_HU, 32'h04, 32'h0, 32'h000000FF, 1'b0, 2, 0);
    issue(1'b0, F3_W,  32'h06, 32'h0, 32'h0, 1'b1, 1, 0);
    issue(1'b1, F3_H,  32'h05, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0);
    check32("err_word1", mem[1], 32'h000000FF);
    issue(1'b1, F3_W,  32'h08, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
    issue(1'b0, F3_W,  32'h08, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
    issue(1'b1, F3_H,  32'h0A, 32'h1234ABCD, 32'h0, 1'b0, 3, 1);
    check32("sh_word2", mem[2], 32'hABCDBEEF);
    issue(1'b0, F3_H,  32'h0A, 32'h0, 32'hFFFFABCD, 1'b0, 2, 0);
    issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0);
    issue(1'b1, F3_BU, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0);
`ifdef LSU_BOUNDS_CHECK_EN
    issue(1'b0, F3_W,  32'h00001000, 32'h0, 32'h0, 1'b1, 1, 0);
`else
    issue(1'b0, F3_W,  32'h00001000, 32'h0, 32'h0, 1'b0, 2, 0);
    check32("unchecked_mem_addr", last_load_addr, 32'h00000400);
`endif

    // Reset during the read half of a halfword store
    we0 = we_cnt;
    rc0 = resp_cnt;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_H;
    req_addr   = 32'h20;
    req_wdata  = 32'h0000FFFF;
    @(negedge clk); #1;
    req_valid = 1'b0;
    check32("rmw_state", 32'(dbg_state), 32'(ST_RMW_RD));
    rst_n = 1'b0;
    #1;
    check32("midrst_mem_we", {31'b0, mem_we}, 32'h0);
    check32("midrst_mem_addr", mem_addr, 32'h0);
    check32("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check32("midrst_we_pulses", 32'(we_cnt - we0), 32'h0);
    check32("midrst_resp_cnt", 32'(resp_cnt - rc0), 32'h0);
    check32("midrst_word8", mem[8], 32'h0A050102);
    check32("midrst_req_ready", {31'b0, req_ready}, 32'h1);

    issue(1'b0, F3_W,  32'h20, 32'h0, 32'h0A050102, 1'b0, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
